mux_filtros_xfade: RTL and testbench

Parametrised, registered successor to the equalizer band-output selector. Chooses one of M signed filter-band outputs (low/mid/high and beyond) for the audio output path. On a selection change it does a linear crossfade over 2^K samples instead of switching hard, which removes audible clicks. It sits between the filter bank outputs and the output/DAC stage and is advanced by the sample strobe.

---
 rtl/mux_filtros_xfade_pkg.sv | 15 +
 rtl/mux_filtros_sel.sv | 21 ++
 rtl/mux_filtros_xfade.sv | 122 ++++++++++++
 tb/tb_mux_filtros_xfade.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mux_filtros_xfade_pkg.sv
// Shared definitions for the band-output selector with crossfade.
package mux_filtros_xfade_pkg;

  localparam int unsigned N_DEF = 23;

  typedef enum logic {
    FILT_IDLE = 1'b0,
    FILT_FADE = 1'b1
  } filt_state_e;

  localparam int unsigned CH_BAJOS  = 0;
  localparam int unsigned CH_MEDIOS = 1;
  localparam int unsigned CH_ALTOS  = 2;

endpackage

// File: rtl/mux_filtros_sel.sv
// Combinational band extractor: returns bandas[idx], out-of-range idx maps to channel 0.
module mux_filtros_sel
  import mux_filtros_xfade_pkg::*;
#(
  parameter int unsigned N    = N_DEF,
  parameter int unsigned M    = 3,
  parameter int unsigned SELW = 2
) (
  input  logic [M*N-1:0]        bandas,
  input  logic [SELW-1:0]       idx,
  output logic signed [N-1:0]   muestra_c
);

  always_comb begin
    muestra_c = bandas[CH_BAJOS*N +: N];
    for (int i = 0; i < int'(M); i++) begin
      if (32'(idx) == 32'(i)) muestra_c = bandas[i*N +: N];
    end
  end

endmodule

// File: rtl/mux_filtros_xfade.sv
// Band selector that crossfades linearly over 2^K samples on a selection change.
module mux_filtros_xfade
  import mux_filtros_xfade_pkg::*;
#(
  parameter int unsigned N    = N_DEF,
  parameter int unsigned M    = 3,
  parameter int unsigned SELW = 2,
  parameter int unsigned K    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [M*N-1:0]        bandas,
  input  logic [SELW-1:0]       caso,
  input  logic                  muestra_valida,
  output logic signed [N-1:0]   sal_mux,
  output logic                  sal_valida,
  output logic                  cambiando
);

  localparam int unsigned L  = 2**K;
  localparam int unsigned PW = N + K + 2;
  localparam int unsigned SW = N + K + 3;

  filt_state_e         state, state_n;
  logic [SELW-1:0]     actual, actual_n, src, src_n, dst, dst_n;
  logic [K-1:0]        j, j_n;
  logic signed [N-1:0] sal_n;
  logic                valida_n, cambiando_n;

  logic [SELW-1:0]     caso_ef_c, src_idx_c;
  logic signed [N-1:0] a_c, b_c;
  logic [K:0]          w_src_c, w_dst_c;
  logic signed [K+1:0] ws_src_c, ws_dst_c;
  logic signed [PW-1:0] p_src_c, p_dst_c;
  logic signed [SW-1:0] suma_c, desp_c;
  logic signed [N-1:0] fade_c;

  assign caso_ef_c = (32'(caso) < M) ? caso : SELW'(CH_BAJOS);
  assign src_idx_c = (state == FILT_IDLE) ? actual : src;

  mux_filtros_sel #(.N(N), .M(M), .SELW(SELW)) u_sel_src (
    .bandas    (bandas),
    .idx       (src_idx_c),
    .muestra_c (a_c)
  );

  mux_filtros_sel #(.N(N), .M(M), .SELW(SELW)) u_sel_dst (
    .bandas    (bandas),
    .idx       (dst),
    .muestra_c (b_c)
  );

  // Convex weighting: (a*(L-j) + b*j) >>> K, floor rounding, never overflows N bits
  always_comb begin
    w_src_c  = (K+1)'(L) - {1'b0, j};
    w_dst_c  = {1'b0, j};
    ws_src_c = $signed({1'b0, w_src_c});
    ws_dst_c = $signed({1'b0, w_dst_c});
    p_src_c  = PW'(a_c) * PW'(ws_src_c);
    p_dst_c  = PW'(b_c) * PW'(ws_dst_c);
    suma_c   = SW'(p_src_c) + SW'(p_dst_c);
    desp_c   = suma_c >>> K;
    fade_c   = N'(desp_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILT_IDLE;
      actual     <= SELW'(CH_BAJOS);
      src        <= '0;
      dst        <= '0;
      j          <= '0;
      sal_mux    <= '0;
      sal_valida <= 1'b0;
      cambiando  <= 1'b0;
    end else begin
      state      <= state_n;
      actual     <= actual_n;
      src        <= src_n;
      dst        <= dst_n;
      j          <= j_n;
      sal_mux    <= sal_n;
      sal_valida <= valida_n;
      cambiando  <= cambiando_n;
    end
  end

  always_comb begin
    state_n  = state;
    actual_n = actual;
    src_n    = src;
    dst_n    = dst;
    j_n      = j;
    sal_n    = sal_mux;
    valida_n = 1'b0;
    if (muestra_valida) begin
      valida_n = 1'b1;
      case (state)
        FILT_IDLE: begin
          sal_n = a_c;
          if (caso_ef_c != actual) begin
            src_n   = actual;
            dst_n   = caso_ef_c;
            j_n     = K'(1);
            state_n = FILT_FADE;
          end
        end
        FILT_FADE: begin
          sal_n = fade_c;
          j_n   = j + K'(1);
          if (j == K'(L - 1)) begin
            actual_n = dst;
            state_n  = FILT_IDLE;
          end
        end
        default: state_n = FILT_IDLE;
      endcase
    end
    cambiando_n = (state_n == FILT_FADE);
  end

endmodule

// File: tb/tb_mux_filtros_xfade.sv
// Self-checking bench for mux_filtros_xfade against a queue-based crossfade model.
module tb_mux_filtros_xfade;
  import mux_filtros_xfade_pkg::*;

  localparam int unsigned N = 23, M = 3, SELW = 2, K = 2;
  localparam int L = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [M*N-1:0]      bandas = '0;
  logic [SELW-1:0]     caso = '0;
  logic                muestra_valida = 1'b0;
  logic signed [N-1:0] sal_mux;
  logic                sal_valida, cambiando;

  int checks = 0;
  int errors = 0;

  // model: fade samples still owed, each as its weight index
  int     fade_q[$];
  int     m_actual = 0, m_src = 0, m_dst = 0;
  longint last_out = 0;

  mux_filtros_xfade #(.N(N), .M(M), .SELW(SELW), .K(K)) dut (
    .clk            (clk),
    .reset          (reset),
    .bandas         (bandas),
    .caso           (caso),
    .muestra_valida (muestra_valida),
    .sal_mux        (sal_mux),
    .sal_valida     (sal_valida),
    .cambiando      (cambiando)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint band(input int i);
    logic signed [N-1:0] t;
    t = bandas[i*N +: N];
    return longint'(t);
  endfunction

  task automatic set_bands(input longint b0, input longint b1, input longint b2);
    bandas = {N'(b2), N'(b1), N'(b0)};
  endtask

  // Reference: a fade is the list of L floor-weighted mixes, then pure destination
  task automatic model_valid(input int c, output longint e, output logic camb);
    int ef;
    int jj;
    if (fade_q.size() > 0) begin
      jj = fade_q.pop_front();
      e  = (band(m_src) * (L - jj) + band(m_dst) * jj) >>> K;
    end else begin
      ef = (c < int'(M)) ? c : 0;
      if (ef == m_actual) begin
        e = band(m_actual);
      end else begin
        m_src = m_actual;
        m_dst = ef;
        for (int k = 1; k < L; k++) fade_q.push_back(k);
        e = band(m_src);
        m_actual = ef;
      end
    end
    camb = (fade_q.size() > 0);
  endtask

  task automatic valid(input int c, input int gap, input string tag);
    longint e;
    logic   camb;
    @(negedge clk);
    caso = SELW'(c);
    muestra_valida = 1'b1;
    model_valid(c, e, camb);
    last_out = e;
    @(negedge clk);
    muestra_valida = 1'b0;
    chk({tag, ".sal"}, sal_mux, e);
    chk({tag, ".val"}, 64'(sal_valida), 64'(1));
    chk({tag, ".camb"}, 64'(cambiando), 64'(camb));
    for (int g = 1; g < gap; g++) begin
      @(negedge clk);
      chk({tag, ".hold"}, sal_mux, last_out);
      chk({tag, ".val0"}, 64'(sal_valida), 64'(0));
    end
  endtask

  task automatic do_reset(input logic with_valid);
    @(negedge clk);
    reset = 1'b1;
    muestra_valida = with_valid;
    @(negedge clk);
    reset = 1'b0;
    muestra_valida = 1'b0;
    fade_q.delete();
    m_actual = 0; m_src = 0; m_dst = 0; last_out = 0;
    @(negedge clk);
    chk("rst.sal", sal_mux, 0);
    chk("rst.val", 64'(sal_valida), 64'(0));
    chk("rst.camb", 64'(cambiando), 64'(0));
  endtask

  initial begin
    set_bands(1000, -1000, 4194303);
    do_reset(1'b0);

    // steady channel 0
    for (int i = 0; i < 3; i++) valid(0, 1, "bajos");
    // 0 -> 1: 1000, 500, 0, -500, then -1000
    valid(1, 1, "f01");
    for (int i = 0; i < 5; i++) valid(1, 1, "f01");
    // out-of-range request falls back to channel 0
    for (int i = 0; i < 6; i++) valid(3, 1, "f10");
    // 0 -> 2, toggle to 1 ignored mid-fade, then new fade to 1
    valid(2, 1, "f02");
    for (int i = 0; i < 8; i++) valid(1, 1, "f21");
    // reset aborts fade at j = 2, sample dropped
    valid(0, 1, "pre");
    valid(0, 1, "pre");
    do_reset(1'b1);
    valid(0, 1, "post");
    chk("post.camb0", 64'(cambiando), 64'(0));
    // spaced valids during fade
    valid(2, 5, "gap5");
    for (int i = 0; i < 5; i++) valid(2, 5, "gap5");
    valid(1, 1, "gap1");
    for (int i = 0; i < 5; i++) valid(1, 1, "gap1");

    // randomized bands, requests and spacing
    for (int i = 0; i < 300; i++) begin
      int c;
      set_bands(longint'($signed(N'($urandom))), longint'($signed(N'($urandom))),
                longint'($signed(N'($urandom))));
      c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : m_actual;
      if ($urandom_range(0, 60) == 0) do_reset(1'(($urandom_range(0, 1))));
      valid(c, int'($urandom_range(1, 3)), "rnd");
    end

    set_bands(1000, -1000, longint'(CH_ALTOS) * 0 + 4194303);
    valid(2, 1, "end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
